// File: rtl/chess_sprite_renderer.sv
// Positioned sprite renderer: power-of-two scaling, palette lookup and keyed transparency.
// Define SPRITE_HIGHLIGHT_EN to add the frame-counter blink that inverts highlighted pixels.
module chess_sprite_renderer #(
   parameter int unsigned SPRITE_W        = 60,
   parameter int unsigned SPRITE_H        = 60,
   parameter int unsigned SCALE_LOG2      = 0,
   parameter int unsigned ADDR_W          = 12,
   parameter int unsigned IDX_W           = 4,
   parameter int unsigned ROM_LAT         = 1,
   parameter int unsigned TRANSPARENT_IDX = 0
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [9:0]        origin_x,
   input  logic [9:0]        origin_y,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [IDX_W-1:0]  rom_q,
   input  logic              pal_we,
   input  logic [IDX_W-1:0]  pal_idx,
   input  logic [11:0]       pal_rgb,
   input  logic              highlight,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              pix_opaque
);

   localparam int unsigned BoxW     = SPRITE_W << SCALE_LOG2;
   localparam int unsigned BoxH     = SPRITE_H << SCALE_LOG2;
   localparam int unsigned PalDepth = 1 << IDX_W;

   logic [10:0]       dx, dy;
   logic [9:0]        tx, ty;
   logic              in_box;
   logic              vis_d;
   logic [ADDR_W-1:0] rom_addr_d, rom_addr_q;
   // Bit 0 is the stage-A register; bit ROM_LAT lines up with rom_q.
   logic [ROM_LAT:0]  vis_sr_q;

   logic [11:0]       pal_q [PalDepth];
   logic [11:0]       colour;
   logic              opaque;
   logic [11:0]       rgb_d, rgb_q;
   logic              pix_opaque_q;

   always_comb begin
      dx     = {1'b0, DrawX} - {1'b0, origin_x};
      dy     = {1'b0, DrawY} - {1'b0, origin_y};
      // Bit 10 set means the pixel is left of / above the origin; never wraps.
      in_box = !dx[10] && !dy[10] && (32'(dx) < BoxW) && (32'(dy) < BoxH);
      tx     = dx[9:0] >> SCALE_LOG2;
      ty     = dy[9:0] >> SCALE_LOG2;
      rom_addr_d = in_box ? ADDR_W'(32'(ty) * SPRITE_W + 32'(tx)) : '0;
      vis_d  = blank & in_box;
   end

`ifdef SPRITE_HIGHLIGHT_EN
   logic [5:0]       frame_d, frame_q;
   logic             hl_d;
   logic [ROM_LAT:0] hl_sr_q;

   always_comb begin
      frame_d = frame_q;
      if (DrawX == 10'd0 && DrawY == 10'd0) begin
         frame_d = frame_q + 6'd1;
      end
      hl_d = highlight & frame_q[5];
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         frame_q <= '0;
         hl_sr_q <= '0;
      end else begin
         frame_q <= frame_d;
         hl_sr_q <= {hl_sr_q[ROM_LAT-1:0], hl_d};
      end
   end
`else
   logic unused_highlight;
   assign unused_highlight = highlight;
`endif

   always_comb begin
      opaque = vis_sr_q[ROM_LAT] && (rom_q != IDX_W'(TRANSPARENT_IDX));
      colour = pal_q[rom_q];
`ifdef SPRITE_HIGHLIGHT_EN
      if (hl_sr_q[ROM_LAT]) begin
         colour = ~colour;
      end
`endif
      rgb_d = opaque ? colour : 12'h000;
   end

   always_ff @(posedge vga_clk) begin
      if (reset) begin
         rom_addr_q   <= '0;
         vis_sr_q     <= '0;
         rgb_q        <= 12'h000;
         pix_opaque_q <= 1'b0;
      end else begin
         rom_addr_q   <= rom_addr_d;
         vis_sr_q     <= {vis_sr_q[ROM_LAT-1:0], vis_d};
         rgb_q        <= rgb_d;
         pix_opaque_q <= opaque;
      end
   end

   // Write lands on the edge, so a same-cycle read of that entry sees the old colour.
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         for (int i = 0; i < int'(PalDepth); i++) begin
            pal_q[i] <= 12'h000;
         end
      end else if (pal_we) begin
         pal_q[pal_idx] <= pal_rgb;
      end
   end

   assign rom_addr           = rom_addr_q;
   assign {red, green, blue} = rgb_q;
   assign pix_opaque         = pix_opaque_q;

endmodule

// File: tb/tb_chess_sprite_renderer.sv
// Randomised plus directed bench for chess_sprite_renderer; two instances (scale 1x/lat 1, 2x/lat 2).
module tb_chess_sprite_renderer;

   localparam int L0 = 3;  // 2 + ROM_LAT for instance 0
   localparam int L1 = 4;  // 2 + ROM_LAT for instance 1

   logic        vga_clk = 1'b0;
   logic        reset = 1'b1;
   logic [9:0]  DrawX = '0, DrawY = '0, origin_x = '0, origin_y = '0;
   logic        blank = 1'b0;
   logic        pal_we = 1'b0;
   logic [3:0]  pal_idx = '0;
   logic [11:0] pal_rgb = '0;
   logic        highlight = 1'b0;

   logic [11:0] rom_addr0, rom_addr1;
   logic [3:0]  rom_q0, rom_q1, rom1_s1;
   logic [3:0]  red0, green0, blue0, red1, green1, blue1;
   logic        op0, op1;

   logic [3:0]  rom_mem [4096];

   int checks = 0;
   int failures = 0;

   always #5 vga_clk = ~vga_clk;

   chess_sprite_renderer #(.SCALE_LOG2(0), .ROM_LAT(1)) u_dut0 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .origin_x(origin_x), .origin_y(origin_y), .rom_addr(rom_addr0), .rom_q(rom_q0),
      .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb), .highlight(highlight),
      .red(red0), .green(green0), .blue(blue0), .pix_opaque(op0)
   );

   chess_sprite_renderer #(.SCALE_LOG2(1), .ROM_LAT(2)) u_dut1 (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
      .origin_x(origin_x), .origin_y(origin_y), .rom_addr(rom_addr1), .rom_q(rom_q1),
      .pal_we(pal_we), .pal_idx(pal_idx), .pal_rgb(pal_rgb), .highlight(highlight),
      .red(red1), .green(green1), .blue(blue1), .pix_opaque(op1)
   );

   // External synchronous ROMs, latency 1 and 2.
   always @(posedge vga_clk) begin
      rom_q0  <= rom_mem[rom_addr0];
      rom1_s1 <= rom_mem[rom_addr1];
      rom_q1  <= rom1_s1;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      bit vis;
      int addr;
      bit hl;
   } rec_t;

   rec_t        rec0 [16];
   rec_t        rec1 [16];
   logic [11:0] pal_m [16];
   int          frame_cnt = 0;
   bit          armed = 0;
   int          n = 0;
   int          exp_addr0 = 0, exp_addr1 = 0, exp_out0 = 0, exp_out1 = 0;

   function automatic rec_t mk(input int sc);
      rec_t r;
      int dx, dy;
      bit inb;
      dx  = int'(DrawX) - int'(origin_x);
      dy  = int'(DrawY) - int'(origin_y);
      inb = (dx >= 0) && (dy >= 0) && (dx < (60 << sc)) && (dy < (60 << sc));
      r.vis  = inb && blank;
      r.addr = inb ? (dy >> sc) * 60 + (dx >> sc) : 0;
`ifdef SPRITE_HIGHLIGHT_EN
      r.hl = highlight && ((frame_cnt & 32) != 0);
`else
      r.hl = 0;
`endif
      return r;
   endfunction

   function automatic int out_of(input rec_t r);
      logic [3:0]  idx;
      logic [11:0] col;
      idx = rom_mem[r.addr];
      col = pal_m[idx];
      if (r.hl) col = ~col;
      if (r.vis && idx != 4'd0) return int'({1'b1, col});
      return 0;
   endfunction

   initial begin
      rec_t r0, r1;
      for (int i = 0; i < 16; i++) begin
         rec0[i] = '{0, 0, 0};
         rec1[i] = '{0, 0, 0};
         pal_m[i] = 12'h000;
      end
      forever begin
         @(posedge vga_clk);
         n++;
         if (reset) begin
            armed = 1;
            for (int i = 0; i < 16; i++) begin
               rec0[i] = '{0, 0, 0};
               rec1[i] = '{0, 0, 0};
               pal_m[i] = 12'h000;
            end
            frame_cnt = 0;
            exp_addr0 = 0; exp_addr1 = 0; exp_out0 = 0; exp_out1 = 0;
         end else begin
            r0 = mk(0);
            r1 = mk(1);
            rec0[n & 15] = r0;
            rec1[n & 15] = r1;
            exp_addr0 = r0.addr;
            exp_addr1 = r1.addr;
            exp_out0  = out_of(rec0[(n - L0 + 1) & 15]);
            exp_out1  = out_of(rec1[(n - L1 + 1) & 15]);
            if (pal_we) pal_m[pal_idx] = pal_rgb;
            if (DrawX == 10'd0 && DrawY == 10'd0) frame_cnt = (frame_cnt + 1) & 63;
         end
         #2;
         if (armed) begin
            chk("m_addr0", int'(rom_addr0), exp_addr0);
            chk("m_out0", int'({op0, red0, green0, blue0}), exp_out0);
            chk("m_addr1", int'(rom_addr1), exp_addr1);
            chk("m_out1", int'({op1, red1, green1, blue1}), exp_out1);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic set_px(input int x, input int y, input int ox, input int oy, input bit b);
      DrawX = 10'(x); DrawY = 10'(y); origin_x = 10'(ox); origin_y = 10'(oy); blank = b;
   endtask

   task automatic hold_px(input int x, input int y, input int ox, input int oy, input bit b);
      @(negedge vga_clk);
      set_px(x, y, ox, oy, b);
      repeat (5) @(posedge vga_clk);
      #2;
   endtask

   int tab_x [7] = '{0, 1, 0, 1, 2, 119, 120};
   int tab_y [7] = '{0, 0, 1, 1, 0, 119, 0};
   int tab_a [7] = '{0, 0, 0, 0, 1, 3599, 0};

   initial begin
      int ox, oy, y;
      for (int i = 0; i < 4096; i++) rom_mem[i] = 4'($urandom_range(0, 15));
      rom_mem[0]   = 4'd3;
      rom_mem[5]   = 4'd0;
      rom_mem[619] = 4'd3;

      set_px(99, 50, 100, 50, 1);
      repeat (3) @(posedge vga_clk);
      #2;
      chk("rst_addr0", int'(rom_addr0), 0);
      chk("rst_out0", int'({op0, red0, green0, blue0}), 0);
      chk("rst_out1", int'({op1, red1, green1, blue1}), 0);
      @(negedge vga_clk);
      reset = 1'b0;
      pal_we = 1'b1; pal_idx = 4'd3; pal_rgb = 12'hF80;
      @(negedge vga_clk);
      pal_we = 1'b0;
      repeat (6) @(negedge vga_clk);

      // Single-cycle pulse at (100,50): output exactly L cycles after sampling.
      set_px(100, 50, 100, 50, 1);
      for (int c = 1; c <= 6; c++) begin
         @(posedge vga_clk);
         #2;
         if (c == 1) set_px(99, 50, 100, 50, 1);
         chk("lat0", int'({op0, red0, green0, blue0}), (c == L0) ? 13'h1F80 : 0);
         chk("lat1", int'({op1, red1, green1, blue1}), (c == L1) ? 13'h1F80 : 0);
      end

      // Scaled addressing, origin (0,0).
      for (int i = 0; i < 7; i++) begin
         @(negedge vga_clk);
         set_px(tab_x[i], tab_y[i], 0, 0, 1);
         @(posedge vga_clk);
         #2;
         chk("addr_x2", int'(rom_addr1), tab_a[i]);
      end
      hold_px(120, 0, 0, 0, 1);
      chk("x2_edge_op", int'(op1), 0);

      hold_px(105, 50, 100, 50, 1);
      chk("transp_out", int'({op0, red0, green0, blue0}), 0);
      hold_px(100, 50, 100, 50, 0);
      chk("blank_out0", int'({op0, red0, green0, blue0}), 0);
      chk("blank_out1", int'({op1, red1, green1, blue1}), 0);

      hold_px(639, 10, 620, 0, 1);
      chk("off_addr", int'(rom_addr0), 619);
      chk("off_out", int'({op0, red0, green0, blue0}), 13'h1F80);
      hold_px(0, 10, 620, 0, 1);
      chk("nowrap_out", int'({op0, red0, green0, blue0}), 0);
      chk("nowrap_addr", int'(rom_addr0), 0);

      // Reset mid-sprite: flush, then palette reads zero but texel stays opaque.
      hold_px(100, 50, 100, 50, 1);
      chk("pre_rst0", int'({op0, red0, green0, blue0}), 13'h1F80);
      @(negedge vga_clk);
      reset = 1'b1;
      @(posedge vga_clk);
      #2;
      chk("rst_mid0", int'({op0, red0, green0, blue0}), 0);
      chk("rst_mid1", int'({op1, red1, green1, blue1}), 0);
      @(negedge vga_clk);
      reset = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         @(posedge vga_clk);
         #2;
         chk("flush0", int'({op0, red0, green0, blue0}), (c >= L0) ? 13'h1000 : 0);
         chk("flush1", int'({op1, red1, green1, blue1}), (c >= L1) ? 13'h1000 : 0);
      end

      // Randomised line sweeps.
      for (int line = 0; line < 28; line++) begin
         ox = $urandom_range(0, 700);
         oy = $urandom_range(0, 500);
         y  = (line == 0) ? 0 : oy + int'($urandom_range(0, 135)) - 5;
         for (int x = 0; x < 800; x++) begin
            @(negedge vga_clk);
            if ($urandom_range(0, 199) == 0) begin
               ox = $urandom_range(0, 700);
               oy = $urandom_range(0, 500);
            end
            set_px(x, y, ox, oy, $urandom_range(0, 9) != 0);
            pal_we    = ($urandom_range(0, 7) == 0);
            pal_idx   = 4'($urandom_range(0, 15));
            pal_rgb   = 12'($urandom_range(0, 4095));
            highlight = 1'($urandom_range(0, 1));
            reset     = ($urandom_range(0, 999) == 0);
         end
      end
      @(negedge vga_clk);
      reset = 1'b0;
      pal_we = 1'b0;
      repeat (6) @(negedge vga_clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
